// File: rtl/npu_ctrl_seq.sv
// NPU control sequencer: host instruction FIFO feeding a three-state
// decode/issue machine that starts the load-store, mover and execution units.
module npu_ctrl_seq #(
    parameter int FIFO_DEPTH = 8,
    parameter int N_EU       = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [31:0]                   h2f_io,
    input  logic                          h2f_write,
    output logic                          h2f_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          isrunning,
    output logic [31:0]                   inst_out,
    output logic                          load_start,
    output logic                          store_start,
    output logic                          move_start,
    input  logic                          ldst_done,
    input  logic                          move_done,
    output logic                          rf_ram_sel,
    output logic [N_EU-1:0]               eu_fetch,
    output logic [N_EU-1:0]               eu_exec,
    output logic                          err_overflow,
    output logic                          err_badunit
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [5:0]    N_EU_C  = 6'(N_EU);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_ISSUE  = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_LOAD  = 3'd1,
        OP_STORE = 3'd2,
        OP_MOVE  = 3'd3,
        OP_FETCH = 3'd4,
        OP_EXEC  = 3'd5,
        OP_SYNC  = 3'd6,
        OP_NOP7  = 3'd7
    } opcode_e;

    logic [31:0]   fifo_mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    state_e        state_r;
    state_e        state_s;
    logic [31:0]   inst_r;
    logic          ldst_busy_r;
    logic          move_busy_r;
    logic          rf_ram_sel_r;
    logic          err_overflow_r;
    logic          err_badunit_r;

    logic          full_s;
    logic          empty_s;
    logic          pop_s;
    logic          push_s;
    logic          overflow_s;
    opcode_e       opcode_s;
    logic [4:0]    unit_s;
    logic          unit_ok_s;
    logic          engines_idle_s;
    logic          issue_s;
    logic          load_s;
    logic          store_s;
    logic          move_s;
    logic          fetch_s;
    logic          exec_s;
    logic          badunit_s;
    logic [31:0]   onehot_s;

    // Field extraction for the instruction sitting in the issue register.
    function automatic opcode_e get_opcode(input logic [31:0] inst);
        return opcode_e'(inst[31:29]);
    endfunction

    function automatic logic [4:0] get_unit(input logic [31:0] inst);
        return inst[28:24];
    endfunction

    assign full_s         = (count_r == DEPTH_C);
    assign empty_s        = (count_r == {CW{1'b0}});
    assign pop_s          = (state_r == ST_IDLE) && !empty_s;
    // A pop on the same edge frees a slot, so a write while full still lands.
    assign push_s         = h2f_write && (!full_s || pop_s);
    assign overflow_s     = h2f_write && full_s && !pop_s;
    assign opcode_s       = get_opcode(inst_r);
    assign unit_s         = get_unit(inst_r);
    assign unit_ok_s      = ({1'b0, unit_s} < N_EU_C);
    assign engines_idle_s = !ldst_busy_r && !move_busy_r;
    assign onehot_s       = 32'd1 << unit_s;

    // Next-state and issue decode.
    always_comb begin
        state_s   = state_r;
        issue_s   = 1'b0;
        load_s    = 1'b0;
        store_s   = 1'b0;
        move_s    = 1'b0;
        fetch_s   = 1'b0;
        exec_s    = 1'b0;
        badunit_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    state_s = ST_DECODE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DECODE: begin
                state_s = ST_ISSUE;
            end
            ST_ISSUE: begin
                case (opcode_s)
                    OP_LOAD: begin
                        issue_s = engines_idle_s;
                        load_s  = engines_idle_s;
                    end
                    OP_STORE: begin
                        issue_s = engines_idle_s;
                        store_s = engines_idle_s;
                    end
                    OP_MOVE: begin
                        issue_s = engines_idle_s;
                        move_s  = engines_idle_s;
                    end
                    OP_SYNC: begin
                        issue_s = engines_idle_s;
                    end
                    OP_FETCH: begin
                        issue_s   = 1'b1;
                        fetch_s   = unit_ok_s;
                        badunit_s = !unit_ok_s;
                    end
                    OP_EXEC: begin
                        issue_s   = 1'b1;
                        exec_s    = unit_ok_s;
                        badunit_s = !unit_ok_s;
                    end
                    default: begin
                        issue_s = 1'b1;
                    end
                endcase
                if (issue_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Engine and EU start pulses, decoded straight from the issue state.
    always_comb begin
        load_start  = load_s;
        store_start = store_s;
        move_start  = move_s;
        if (fetch_s) begin
            eu_fetch = onehot_s[N_EU-1:0];
        end else begin
            eu_fetch = {N_EU{1'b0}};
        end
        if (exec_s) begin
            eu_exec = onehot_s[N_EU-1:0];
        end else begin
            eu_exec = {N_EU{1'b0}};
        end
    end

    // Queue storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= h2f_io;
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sequencer state, issue register and RAM ownership.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            inst_r       <= 32'd0;
            rf_ram_sel_r <= 1'b0;
        end else begin
            state_r <= state_s;
            if (pop_s) begin
                inst_r <= fifo_mem_r[rd_ptr_r];
            end
            if (load_s || store_s) begin
                rf_ram_sel_r <= 1'b1;
            end else if (move_s) begin
                rf_ram_sel_r <= 1'b0;
            end
        end
    end

    // Engine busy tracking; a start wins over a coincident done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ldst_busy_r <= 1'b0;
            move_busy_r <= 1'b0;
        end else begin
            if (load_s || store_s) begin
                ldst_busy_r <= 1'b1;
            end else if (ldst_done) begin
                ldst_busy_r <= 1'b0;
            end
            if (move_s) begin
                move_busy_r <= 1'b1;
            end else if (move_done) begin
                move_busy_r <= 1'b0;
            end
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_overflow_r <= 1'b0;
            err_badunit_r  <= 1'b0;
        end else begin
            if (overflow_s) begin
                err_overflow_r <= 1'b1;
            end
            if (badunit_s) begin
                err_badunit_r <= 1'b1;
            end
        end
    end

    assign h2f_full     = full_s;
    assign fifo_count   = count_r;
    assign inst_out     = inst_r;
    assign rf_ram_sel   = rf_ram_sel_r;
    assign err_overflow = err_overflow_r;
    assign err_badunit  = err_badunit_r;
    assign isrunning    = (state_r != ST_IDLE) || !empty_s || ldst_busy_r || move_busy_r;

endmodule

// File: tb/tb_npu_ctrl_seq.sv
// Directed bench for npu_ctrl_seq: stimulus pushes expected pulses into a
// scoreboard queue, a negedge monitor pops and compares on every pulse.
module tb_npu_ctrl_seq;

    logic        clk;
    logic        rst_n;
    logic [31:0] h2f_io;
    logic        h2f_write;
    logic        h2f_full;
    logic [3:0]  fifo_count;
    logic        isrunning;
    logic [31:0] inst_out;
    logic        load_start;
    logic        store_start;
    logic        move_start;
    logic        ldst_done;
    logic        move_done;
    logic        rf_ram_sel;
    logic [3:0]  eu_fetch;
    logic [3:0]  eu_exec;
    logic        err_overflow;
    logic        err_badunit;

    int total = 0;
    int bad   = 0;

    // {load, store, move, fetch[3:0], exec[3:0]} , inst_out
    logic [42:0] exp_q [$];
    logic [42:0] mon_e;
    logic [10:0] mon_p;

    logic [31:0] t3_words [9];
    logic [10:0] t3_pulse [9];
    logic [31:0] t4_words [6];
    logic [10:0] t4_pulse [6];
    logic        t4_has   [6];

    npu_ctrl_seq #(.FIFO_DEPTH(8), .N_EU(4)) dut (
        .clk(clk), .rst_n(rst_n), .h2f_io(h2f_io), .h2f_write(h2f_write),
        .h2f_full(h2f_full), .fifo_count(fifo_count), .isrunning(isrunning),
        .inst_out(inst_out), .load_start(load_start), .store_start(store_start),
        .move_start(move_start), .ldst_done(ldst_done), .move_done(move_done),
        .rf_ram_sel(rf_ram_sel), .eu_fetch(eu_fetch), .eu_exec(eu_exec),
        .err_overflow(err_overflow), .err_badunit(err_badunit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic write_word(input logic [31:0] w);
        h2f_io    = w;
        h2f_write = 1'b1;
        @(negedge clk);
        h2f_write = 1'b0;
    endtask

    // Monitor: every observed pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        mon_p = {load_start, store_start, move_start, eu_fetch, eu_exec};
        if (mon_p != 11'd0) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got %0h inst %0h expected none", mon_p, inst_out);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse", {21'd0, mon_p, inst_out}, {21'd0, mon_e});
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        t3_words = '{32'h8000_0011, 32'h8100_0012, 32'h8200_0013, 32'h8300_0014,
                     32'hA000_0021, 32'hA100_0022, 32'hA200_0023, 32'hA300_0024,
                     32'hA300_00FF};
        t3_pulse = '{11'b000_0001_0000, 11'b000_0010_0000, 11'b000_0100_0000, 11'b000_1000_0000,
                     11'b000_0000_0001, 11'b000_0000_0010, 11'b000_0000_0100, 11'b000_0000_1000,
                     11'b000_0000_0000};
        t4_words = '{32'hA200_0031, 32'hA500_0032, 32'h0000_0033, 32'hE000_0034,
                     32'h8100_0035, 32'h4000_0036};
        t4_pulse = '{11'b000_0000_0100, 11'd0, 11'd0, 11'd0, 11'b000_0010_0000, 11'b010_0000_0000};
        t4_has   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        rst_n = 1'b0; h2f_io = 32'd0; h2f_write = 1'b0; ldst_done = 1'b0; move_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_count", fifo_count, 4'd0);
        check("rst_outs", {h2f_full, isrunning, rf_ram_sel, err_overflow, err_badunit}, 5'd0);
        check("rst_inst", inst_out, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single LOAD: latency and rf_ram_sel
        exp_q.push_back({11'b100_0000_0000, 32'h2000_00AB});
        write_word(32'h2000_00AB);
        check("t1_count_e0", fifo_count, 4'd1);
        check("t1_load_e0", load_start, 1'b0);
        @(negedge clk);
        check("t1_count_e1", fifo_count, 4'd0);
        check("t1_inst_e1", inst_out, 32'h2000_00AB);
        check("t1_load_e1", load_start, 1'b0);
        @(negedge clk);
        check("t1_load_e2", load_start, 1'b1);
        @(negedge clk);
        check("t1_load_e3", load_start, 1'b0);
        check("t1_rfsel", rf_ram_sel, 1'b1);
        repeat (5) @(negedge clk);
        check("t1_running", isrunning, 1'b1);
        ldst_done = 1'b1;
        @(negedge clk);
        ldst_done = 1'b0;
        check("t1_idle", isrunning, 1'b0);

        // LOAD then MOVE: MOVE waits for ldst_done
        exp_q.push_back({11'b100_0000_0000, 32'h2000_0001});
        exp_q.push_back({11'b001_0000_0000, 32'h6000_0002});
        write_word(32'h2000_0001);
        write_word(32'h6000_0002);
        n = 0;
        while (!load_start && n < 10) begin @(negedge clk); n++; end
        check("t2_load_seen", load_start, 1'b1);
        repeat (10) @(negedge clk);
        check("t2_move_stall", move_start, 1'b0);
        check("t2_inst_stall", inst_out, 32'h6000_0002);
        check("t2_rfsel_ldst", rf_ram_sel, 1'b1);
        ldst_done = 1'b1;
        @(negedge clk);
        ldst_done = 1'b0;
        check("t2_move_go", move_start, 1'b1);
        @(negedge clk);
        check("t2_move_once", move_start, 1'b0);
        check("t2_rfsel_move", rf_ram_sel, 1'b0);
        move_done = 1'b1;
        @(negedge clk);
        move_done = 1'b0;
        check("t2_idle", isrunning, 1'b0);

        // Fill queue behind a stalled SYNC, overflow on the 9th write
        exp_q.push_back({11'b100_0000_0000, 32'h2000_0003});
        write_word(32'h2000_0003);
        n = 0;
        while (!load_start && n < 10) begin @(negedge clk); n++; end
        check("t3_load_seen", load_start, 1'b1);
        write_word(32'hC000_0004);
        repeat (4) @(negedge clk);
        check("t3_sync_stall", {fifo_count, inst_out}, {4'd0, 32'hC000_0004});
        for (int i = 0; i < 9; i++) begin
            if (i < 8) exp_q.push_back({t3_pulse[i], t3_words[i]});
            h2f_io    = t3_words[i];
            h2f_write = 1'b1;
            @(negedge clk);
            if (i == 7) begin
                check("t3_full", h2f_full, 1'b1);
                check("t3_count8", fifo_count, 4'd8);
                check("t3_no_ovf_yet", err_overflow, 1'b0);
            end
        end
        h2f_write = 1'b0;
        check("t3_count_hold", fifo_count, 4'd8);
        check("t3_ovf", err_overflow, 1'b1);
        ldst_done = 1'b1;
        @(negedge clk);
        ldst_done = 1'b0;
        n = 0;
        while (isrunning && n < 60) begin @(negedge clk); n++; end
        check("t3_drained", isrunning, 1'b0);
        check("t3_sb_empty", exp_q.size(), 0);

        // EU index range, NOPs, STORE
        check("t4_badunit_pre", err_badunit, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (t4_has[i]) exp_q.push_back({t4_pulse[i], t4_words[i]});
            write_word(t4_words[i]);
        end
        n = 0;
        while (!store_start && n < 40) begin @(negedge clk); n++; end
        check("t4_store_seen", store_start, 1'b1);
        @(negedge clk);
        check("t4_rfsel", rf_ram_sel, 1'b1);
        check("t4_badunit", err_badunit, 1'b1);
        ldst_done = 1'b1;
        @(negedge clk);
        ldst_done = 1'b0;
        check("t4_idle", isrunning, 1'b0);

        // SYNC stalled behind MOVE, reset during the stall
        exp_q.push_back({11'b001_0000_0000, 32'h6000_0040});
        write_word(32'h6000_0040);
        n = 0;
        while (!move_start && n < 10) begin @(negedge clk); n++; end
        check("t5_move_seen", move_start, 1'b1);
        write_word(32'hC000_0041);
        repeat (6) @(negedge clk);
        check("t5_sync_stall", {isrunning, inst_out}, {1'b1, 32'hC000_0041});
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_rst_count", fifo_count, 4'd0);
        check("t5_rst_flags", {h2f_full, isrunning, rf_ram_sel, err_overflow, err_badunit}, 5'd0);
        check("t5_rst_inst", inst_out, 32'd0);
        check("t5_rst_pulses", {load_start, store_start, move_start, eu_fetch, eu_exec}, 11'd0);
        rst_n = 1'b1;
        @(negedge clk);
        move_done = 1'b1;
        @(negedge clk);
        move_done = 1'b0;
        check("t5_late_done", isrunning, 1'b0);
        exp_q.push_back({11'b100_0000_0000, 32'h2000_0051});
        write_word(32'h2000_0051);
        n = 0;
        while (!load_start && n < 6) begin @(negedge clk); n++; end
        check("t5_load_after_rst", load_start, 1'b1);
        @(negedge clk);
        ldst_done = 1'b1;
        @(negedge clk);
        ldst_done = 1'b0;
        repeat (2) @(negedge clk);
        check("end_sb_empty", exp_q.size(), 0);
        check("end_idle", isrunning, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/npu_ctrl_seq.md
NPU_CTRL_SEQ -- requirements
Module: npu_ctrl_seq

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, instruction queue depth; power of two, at least 2.
REQ-002 Parameter N_EU, default 32, number of execution units; 2..32.
REQ-003 Port clk  input  1  clock, all state on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port h2f_io  input  32  host instruction word.
REQ-006 Port h2f_write  input  1  host write strobe, one instruction per cycle high.
REQ-007 Port h2f_full  output  1  queue full.
REQ-008 Port fifo_count  output  $clog2(FIFO_DEPTH)+1  queue occupancy.
REQ-009 Port isrunning  output  1  sequencer or any engine active.
REQ-010 Port inst_out  output  32  instruction held in issue register, payload for mover, load-storer and EU.
REQ-011 Ports load_start, store_start, move_start  output  1 each  one-cycle engine start pulses.
REQ-012 Ports ldst_done, move_done  input  1 each  one-cycle engine completion pulses.
REQ-013 Port rf_ram_sel  output  1  rf RAM owner: 1 = ldst, 0 = move.
REQ-014 Ports eu_fetch, eu_exec  output  N_EU each  one-hot EU pulses.
REQ-015 Ports err_overflow, err_badunit  output  1 each  sticky error flags.

Function
REQ-016 Instruction fields: opcode = bits[31:29], unit index = bits[28:24]. Opcodes: 0 NOP, 1 LOAD, 2 STORE, 3 MOVE, 4 FETCH, 5 EXEC, 6 SYNC, 7 NOP.
REQ-017 Queue is a FIFO. A h2f_write sampled while not full pushes h2f_io; a write while full is dropped and sets err_overflow.
REQ-018 h2f_full is high when fifo_count == FIFO_DEPTH. Read/write pointers wrap modulo FIFO_DEPTH.
REQ-019 FSM states: IDLE, DECODE, ISSUE.
- IDLE -> DECODE when the queue is non-empty; the head is popped into the issue register on that edge.
- DECODE -> ISSUE unconditionally.
- ISSUE -> IDLE when the instruction issues; otherwise stays in ISSUE (stall).
REQ-020 Push and pop on the same edge leave fifo_count unchanged. A push while full that coincides with a pop is accepted.
REQ-021 Busy flags ldst_busy and move_busy:
- set by the corresponding start pulse;
- cleared by the corresponding done pulse;
- start and done in the same cycle leave the flag set;
- done while not busy is ignored.
REQ-022 Issue conditions in ISSUE:
- LOAD/STORE issue when ldst_busy == 0 and move_busy == 0.
- MOVE issues when move_busy == 0 and ldst_busy == 0.
- SYNC issues when both flags are 0.
- FETCH/EXEC/NOP issue immediately.
REQ-023 On issue, exactly one pulse is asserted combinationally from state:
- load_start, store_start or move_start;
- or eu_fetch/eu_exec bit [unit], all other bits 0.
REQ-024 On issue, rf_ram_sel is registered to 1 for LOAD/STORE and to 0 for MOVE; it holds otherwise.
REQ-025 FETCH/EXEC with unit >= N_EU produces no pulse, sets err_badunit, and the instruction is consumed.
REQ-026 NOP/SYNC produce no pulse.
REQ-027 Minimum latency: write sampled at edge E0, pop at E1, pulse high for the cycle between E2 and E3. Back-to-back non-stalled throughput is one instruction per 3 cycles.
REQ-028 isrunning = (state != IDLE) | (fifo_count != 0) | ldst_busy | move_busy.
REQ-029 inst_out holds its value until the next pop.

Reset
REQ-030 While rst_n is low:
- state = IDLE; the FIFO is emptied (pointers and count 0);
- busy flags are 0, rf_ram_sel = 0, inst_out = 0;
- error flags are 0; all pulses are 0.
REQ-031 Reset asserted mid-stall or mid-engine-operation discards all queued and in-flight state. Done pulses arriving after reset are ignored.

Verification
REQ-032 Write LOAD at E0 -> load_start high only between E2 and E3; rf_ram_sel = 1 after E3; isrunning stays high until ldst_done.
REQ-033 Write LOAD then MOVE back-to-back, ldst_done 10 cycles after load_start -> move_start is asserted exactly 1 cycle after ldst_done is sampled, and rf_ram_sel = 0 afterwards.
REQ-034 FIFO_DEPTH = 8: write 9 instructions with the engine busy -> h2f_full high after the 8th; 9th dropped; err_overflow = 1; 8 instructions issue after done.
REQ-035 N_EU = 4: EXEC unit 2 -> eu_exec = 4'b0100 for 1 cycle; EXEC unit 5 -> no pulse, err_badunit = 1, next instruction proceeds.
REQ-036 MOVE issued, SYNC queued -> SYNC stalls in ISSUE until move_done. Assert rst_n low during the stall -> all outputs at reset values; a later move_done has no effect.
